// File: rtl/sum_diff_cmp_pipe_pkg.sv
// sum_diff_cmp_pipe_pkg: shared types and compare helper for the sum/diff comparison pipeline
package sum_diff_cmp_pipe_pkg;

    localparam int MAX_W = 16;

    typedef enum logic {
        MODE_WRAP  = 1'b0,
        MODE_EXACT = 1'b1
    } mode_t;

    // Stage-1 payload sized for the widest legal operand; sum is zero-extended, diff sign-extended.
    typedef struct packed {
        logic [MAX_W:0]   sum;
        logic [MAX_W+1:0] diff;
        logic             carry;
        logic             borrow;
        mode_t            mode;
    } s1_t;

    // Extension preserves values, so the exact compare can run at the full payload width.
    function automatic logic cmp_result(s1_t p, int unsigned w);
        logic [MAX_W:0] m;
        m = (MAX_W+1)'((32'd1 << w) - 32'd1);
        return p.mode == MODE_EXACT ? $signed({1'b0, p.sum}) < $signed(p.diff)
                                    : (p.sum & m) < (p.diff[MAX_W:0] & m);
    endfunction

endpackage

// File: rtl/sum_diff_cmp_pipe_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear that overrides increment
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;

endmodule

// File: rtl/sum_diff_cmp_pipe.sv
// sum_diff_cmp_pipe: two-stage valid/ready pipeline computing (a + b) < (c - d) with a true-result counter
module sum_diff_cmp_pipe
    import sum_diff_cmp_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic             carry,
    output logic             borrow,
    input  logic             clr,
    output logic [CNT_W-1:0] true_count
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;
    s1_t              p;
    s1_t              s1;
    logic             s1_v;
    logic             adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage-1 arithmetic on the incoming operand set.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {2'b00, c} - {2'b00, d};
        p.sum    = (MAX_W+1)'(sum);
        p.diff   = (MAX_W+2)'($signed(diff));
        p.carry  = sum[WIDTH];
        p.borrow = c < d;
        p.mode   = mode_t'(mode);
    end

    // Both stages move together on adv; a stall freezes payloads and valid bits.
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            s1_v      <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            out       <= 1'b0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
        end else if (adv) begin
            s1_v      <= in_valid;
            s1        <= p;
            out_valid <= s1_v;
            out       <= cmp_result(s1, WIDTH);
            carry     <= s1.carry;
            borrow    <= s1.borrow;
        end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock  (clock),
        .reset_L(reset_L),
        .inc    (out_valid && out_ready && out),
        .clr    (clr),
        .count  (true_count)
    );

endmodule

// File: doc/sum_diff_cmp_pipe.md
SUM_DIFF_CMP_PIPE -- requirements
Module: sum_diff_cmp_pipe

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand width in bits; legal range is 2..16.
REQ-002 Parameter CNT_W, default 8, sets the width of the true-result counter.
REQ-003 clock  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset_L  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set on the input is valid.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b, c, d  input  WIDTH each  operands of (a + b) < (c - d).
REQ-008 mode  input  1  0 = wrap (modulo 2^WIDTH), 1 = exact (full-precision); sampled with the operands.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out  output  1  comparison result.
REQ-012 carry  output  1  a + b exceeded 2^WIDTH - 1.
REQ-013 borrow  output  1  c < d.
REQ-014 clr  input  1  synchronous clear of true_count.
REQ-015 true_count  output  CNT_W  saturating count of delivered results with out = 1.

Function
REQ-016 Input handshake fires on in_valid && in_ready; output handshake fires on out_valid && out_ready.
REQ-017 Pipeline has 2 register stages: S1 holds sum, diff, carry, borrow and mode; S2 holds out, carry and borrow.
REQ-018 A global advance enable, adv = !out_valid || out_ready, moves both stages; in_ready = adv.
REQ-019 Unstalled latency is 2 cycles: an operand set accepted at edge N gives out_valid at edge N+2.
REQ-020 Stall: out_valid && !out_ready holds both stages and their valid bits unchanged, with no loss or duplication.
REQ-021 A bubble enters S1 when adv && !in_valid.
REQ-022 sum is computed at WIDTH+1 bits; carry = sum[WIDTH].
REQ-023 diff is computed signed at WIDTH+2 bits; borrow = (c < d) as unsigned values.
REQ-024 Mode 0: out = sum[WIDTH-1:0] < diff[WIDTH-1:0], compared unsigned.
REQ-025 Mode 1: out = signed(sum, zero-extended) < signed(diff), compared at WIDTH+2 bits.
REQ-026 Mode travels with its operand set, so results of mixed-mode streams are independent of each other.
REQ-027 true_count increments by 1 on each output handshake with out = 1.
REQ-028 true_count saturates at 2^CNT_W - 1.
REQ-029 When clr is asserted in the same cycle as an increment, clr wins and true_count becomes 0.
REQ-030 out, carry and borrow are don't-care while out_valid = 0.

Reset
REQ-031 While reset_L = 0, S1 and S2 valid bits, out_valid, out, carry, borrow and true_count are all 0, immediately and without waiting for a clock edge.
REQ-032 Reset mid-operation discards all in-flight results; no result is delivered after reset deasserts.
REQ-033 in_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-034 A shared package holds the mode_t enum (MODE_WRAP = 0, MODE_EXACT = 1) and the S1 payload struct typedef.
REQ-035 One sub-module, sat_counter (parameter CNT_W; inputs inc and clr), implements true_count.

Verification (WIDTH = 4, CNT_W = 3)
REQ-036 a=1, b=1, c=15, d=1, mode 0 -> out=1, carry=0, borrow=0, with out_valid exactly 2 cycles after acceptance.
REQ-037 a=15, b=1, c=2, d=0 -> mode 0: out=1, carry=1; mode 1: out=0, carry=1.
REQ-038 a=0, b=0, c=0, d=1 -> mode 0: out=1 (0<15), borrow=1; mode 1: out=0 (0<-1), borrow=1.
REQ-039 out_ready=0 with three back-to-back sets A, B, C -> A and B accepted, then in_ready=0; after out_ready=1, results arrive in order A, B, C, each exactly once.
REQ-040 Nine out=1 results delivered -> true_count=7 (saturated); clr together with an out=1 handshake -> true_count=0.
REQ-041 reset_L pulsed low while two results are in flight -> out_valid and true_count go to 0 at once, and no stale result appears after release.
